// File: rtl/imm_decode_stage_if.sv
// Bus bundle for imm_decode_stage: fetch handshake, immediate mux select/return,
// and the decoded-entry handshake toward execute.
interface imm_decode_stage_if #(
   parameter int XLEN = 64,
   parameter int PC_W = 64
);
   logic            instr_valid_in;
   logic            instr_ready_out;
   logic [31:0]     instr_in;
   logic [PC_W-1:0] pc_in;
   logic [2:0]      imm_sel_out;
   logic [XLEN-1:0] imm_value_in;
   logic            dec_valid_out;
   logic            dec_ready_in;
   logic [31:0]     dec_instr_out;
   logic [PC_W-1:0] dec_pc_out;
   logic [XLEN-1:0] dec_imm_out;
   logic [2:0]      dec_fmt_out;
   logic            illegal_out;

   modport slave (
      input  instr_valid_in, instr_in, pc_in, imm_value_in, dec_ready_in,
      output instr_ready_out, imm_sel_out, dec_valid_out, dec_instr_out,
             dec_pc_out, dec_imm_out, dec_fmt_out, illegal_out
   );

   modport master (
      output instr_valid_in, instr_in, pc_in, imm_value_in, dec_ready_in,
      input  instr_ready_out, imm_sel_out, dec_valid_out, dec_instr_out,
             dec_pc_out, dec_imm_out, dec_fmt_out, illegal_out
   );
endinterface

// File: rtl/imm_decode_stage.sv
// Decode stage: immediate-format classification plus a 2-entry skid pipeline register.
// Optional macro IMM_ILLEGAL_TRAP_EN: unknown opcodes become NONE and are flagged illegal.
module imm_decode_stage #(
   parameter int XLEN = 64,
   parameter int PC_W = 64
) (
   input  logic               clk_in,
   input  logic               reset_in,
   input  logic               flush_in,
   imm_decode_stage_if.slave  bus
);

   localparam logic [2:0] FMT_I     = 3'd0;
   localparam logic [2:0] FMT_S     = 3'd1;
   localparam logic [2:0] FMT_B     = 3'd2;
   localparam logic [2:0] FMT_U     = 3'd3;
   localparam logic [2:0] FMT_J     = 3'd4;
   localparam logic [2:0] FMT_SHAMT = 3'd5;
   localparam logic [2:0] FMT_ZIMM  = 3'd6;
   localparam logic [2:0] FMT_NONE  = 3'd7;

   typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;

   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
   } entry_t;

   localparam entry_t ENTRY_RST = '{instr: '0, pc: '0, imm: '0, fmt: FMT_NONE};

   state_e state_q, state_d;
   entry_t out_q, skid_q, new_entry;
   logic [2:0] fmt_dec;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic accept, issue, valid, ready;
   logic load_out, load_skid, skid_to_out;
`ifdef IMM_ILLEGAL_TRAP_EN
   logic unknown_dec;
   logic out_ill_q, skid_ill_q;
`endif

   assign opcode = bus.instr_in[6:0];
   assign funct3 = bus.instr_in[14:12];

   always_comb begin
      fmt_dec = FMT_I;
`ifdef IMM_ILLEGAL_TRAP_EN
      unknown_dec = 1'b0;
`endif
      case (opcode)
         7'b0000011, 7'b1100111, 7'b0001111: fmt_dec = FMT_I;
         7'b0010011, 7'b0011011:
            fmt_dec = (funct3 == 3'b001 || funct3 == 3'b101) ? FMT_SHAMT : FMT_I;
         7'b0100011: fmt_dec = FMT_S;
         7'b1100011: fmt_dec = FMT_B;
         7'b0110111, 7'b0010111: fmt_dec = FMT_U;
         7'b1101111: fmt_dec = FMT_J;
         7'b1110011: fmt_dec = funct3[2] ? FMT_ZIMM : FMT_I;
         7'b0110011, 7'b0111011: fmt_dec = FMT_NONE;
         default: begin
`ifdef IMM_ILLEGAL_TRAP_EN
            fmt_dec     = FMT_NONE;
            unknown_dec = 1'b1;
`else
            fmt_dec     = FMT_I;
`endif
         end
      endcase
   end

   assign bus.imm_sel_out = fmt_dec;

   // NONE-format entries carry a zero immediate regardless of what the mux returns
   always_comb begin
      new_entry.instr = bus.instr_in;
      new_entry.pc    = bus.pc_in;
      new_entry.fmt   = fmt_dec;
      new_entry.imm   = (fmt_dec == FMT_NONE) ? '0 : bus.imm_value_in;
   end

   // Ready depends only on the state register, never on dec_ready_in
   assign valid  = (state_q != EMPTY);
   assign ready  = (state_q != SKID);
   assign accept = bus.instr_valid_in & ready;
   assign issue  = valid & bus.dec_ready_in;

   always_comb begin
      state_d     = state_q;
      load_out    = 1'b0;
      load_skid   = 1'b0;
      skid_to_out = 1'b0;
      if (flush_in) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d  = FULL;
                  load_out = 1'b1;
               end
            end
            FULL: begin
               if (accept && issue) begin
                  load_out = 1'b1;
               end else if (accept) begin
                  state_d   = SKID;
                  load_skid = 1'b1;
               end else if (issue) begin
                  state_d = EMPTY;
               end
            end
            SKID: begin
               if (issue) begin
                  state_d     = FULL;
                  skid_to_out = 1'b1;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q <= EMPTY;
         out_q   <= ENTRY_RST;
         skid_q  <= ENTRY_RST;
      end else begin
         state_q <= state_d;
         if (load_out)         out_q <= new_entry;
         else if (skid_to_out) out_q <= skid_q;
         if (load_skid)        skid_q <= new_entry;
      end
   end

`ifdef IMM_ILLEGAL_TRAP_EN
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         out_ill_q  <= 1'b0;
         skid_ill_q <= 1'b0;
      end else begin
         if (load_out)         out_ill_q <= unknown_dec;
         else if (skid_to_out) out_ill_q <= skid_ill_q;
         if (load_skid)        skid_ill_q <= unknown_dec;
      end
   end
   assign bus.illegal_out = valid & out_ill_q;
`else
   assign bus.illegal_out = 1'b0;
`endif

   assign bus.instr_ready_out = ready;
   assign bus.dec_valid_out   = valid;
   assign bus.dec_instr_out   = out_q.instr;
   assign bus.dec_pc_out      = out_q.pc;
   assign bus.dec_imm_out     = out_q.imm;
   assign bus.dec_fmt_out     = out_q.fmt;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage; models the immediate mux combinationally.
module tb_imm_decode_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   imm_decode_stage_if #(.XLEN(64), .PC_W(64)) bus ();

   imm_decode_stage #(.XLEN(64), .PC_W(64)) dut (
      .clk_in   (clk),
      .reset_in (rst),
      .flush_in (flush),
      .bus      (bus)
   );

   // Reference immediate generator; NONE returns garbage the DUT must ignore
   function automatic logic [63:0] mux_imm(input logic [31:0] i, input logic [2:0] s);
      case (s)
         3'd0: mux_imm = {{52{i[31]}}, i[31:20]};
         3'd1: mux_imm = {{52{i[31]}}, i[31:25], i[11:7]};
         3'd2: mux_imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
         3'd3: mux_imm = {{32{i[31]}}, i[31:12], 12'b0};
         3'd4: mux_imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
         3'd5: mux_imm = {58'b0, i[25:20]};
         3'd6: mux_imm = {59'b0, i[19:15]};
         default: mux_imm = 64'hDEAD_BEEF_DEAD_BEEF;
      endcase
   endfunction

   assign bus.imm_value_in = mux_imm(bus.instr_in, bus.imm_sel_out);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.instr_valid_in = 1'b0;
      bus.instr_in = 32'h0;
      bus.pc_in = 64'h0;
      bus.dec_ready_in = 1'b0;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (bus.dec_valid_out !== 1'b0) begin
         errors++; $display("FAIL reset_valid: got %b expected 0", bus.dec_valid_out);
      end
      checks++;
      if (bus.instr_ready_out !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b expected 1", bus.instr_ready_out);
      end
      checks++;
      if (bus.dec_fmt_out !== 3'd7) begin
         errors++; $display("FAIL reset_fmt: got %0d expected 7", bus.dec_fmt_out);
      end
      checks++;
      if (bus.dec_instr_out !== 32'h0 || bus.dec_pc_out !== 64'h0 || bus.dec_imm_out !== 64'h0) begin
         errors++; $display("FAIL reset_data: got instr %h pc %h imm %h expected zeros",
                            bus.dec_instr_out, bus.dec_pc_out, bus.dec_imm_out);
      end
      checks++;
      if (bus.illegal_out !== 1'b0) begin
         errors++; $display("FAIL reset_illegal: got %b expected 0", bus.illegal_out);
      end
   endtask

   task automatic test_addi();
      bus.dec_ready_in = 1'b1;
      bus.instr_valid_in = 1'b1;
      bus.instr_in = 32'hFFF00093;
      bus.pc_in = 64'h1000;
      #1;
      checks++;
      if (bus.imm_sel_out !== 3'd0) begin
         errors++; $display("FAIL addi_sel: got %0d expected 0", bus.imm_sel_out);
      end
      step();
      bus.instr_valid_in = 1'b0;
      checks++;
      if (bus.dec_valid_out !== 1'b1 || bus.dec_fmt_out !== 3'd0) begin
         errors++; $display("FAIL addi_out: got valid %b fmt %0d expected 1 0",
                            bus.dec_valid_out, bus.dec_fmt_out);
      end
      checks++;
      if (bus.dec_imm_out !== 64'hFFFF_FFFF_FFFF_FFFF || bus.dec_pc_out !== 64'h1000 ||
          bus.dec_instr_out !== 32'hFFF00093) begin
         errors++; $display("FAIL addi_data: got imm %h pc %h instr %h expected ffffffffffffffff 1000 fff00093",
                            bus.dec_imm_out, bus.dec_pc_out, bus.dec_instr_out);
      end
      step();
      checks++;
      if (bus.dec_valid_out !== 1'b0) begin
         errors++; $display("FAIL addi_drain: got valid %b expected 0", bus.dec_valid_out);
      end
   endtask

   task automatic test_formats();
      logic [31:0] ins [7];
      logic [2:0]  fmt [7];
      logic [63:0] imm [7];
      ins[0] = 32'h00309093; fmt[0] = 3'd5; imm[0] = 64'd3;
      ins[1] = 32'h00112023; fmt[1] = 3'd1; imm[1] = 64'd0;
      ins[2] = 32'h00000463; fmt[2] = 3'd2; imm[2] = 64'd8;
      ins[3] = 32'h123450B7; fmt[3] = 3'd3; imm[3] = 64'h12345000;
      ins[4] = 32'h0080006F; fmt[4] = 3'd4; imm[4] = 64'd8;
      ins[5] = 32'h3405D073; fmt[5] = 3'd6; imm[5] = 64'd11;
      ins[6] = 32'h002081B3; fmt[6] = 3'd7; imm[6] = 64'd0;
      bus.dec_ready_in = 1'b1;
      for (int k = 0; k < 7; k++) begin
         bus.instr_valid_in = 1'b1;
         bus.instr_in = ins[k];
         bus.pc_in = 64'h4000 + 64'(4 * k);
         step();
         checks++;
         if (bus.dec_valid_out !== 1'b1 || bus.dec_fmt_out !== fmt[k] || bus.dec_imm_out !== imm[k] ||
             bus.dec_instr_out !== ins[k]) begin
            errors++; $display("FAIL fmt_%0d: got valid %b fmt %0d imm %h instr %h expected 1 %0d %h %h",
                               k, bus.dec_valid_out, bus.dec_fmt_out, bus.dec_imm_out,
                               bus.dec_instr_out, fmt[k], imm[k], ins[k]);
         end
      end
      bus.instr_valid_in = 1'b0;
      step();
      checks++;
      if (bus.dec_valid_out !== 1'b0) begin
         errors++; $display("FAIL fmt_drain: got valid %b expected 0", bus.dec_valid_out);
      end
   endtask

   task automatic test_back_to_back();
      bus.dec_ready_in = 1'b0;
      bus.instr_valid_in = 1'b1;
      bus.instr_in = 32'h00100093;
      bus.pc_in = 64'h2000;
      step();
      checks++;
      if (bus.instr_ready_out !== 1'b1 || bus.dec_valid_out !== 1'b1) begin
         errors++; $display("FAIL b2b_first: got ready %b valid %b expected 1 1",
                            bus.instr_ready_out, bus.dec_valid_out);
      end
      bus.instr_in = 32'h00200113;
      bus.pc_in = 64'h2004;
      step();
      bus.instr_valid_in = 1'b0;
      checks++;
      if (bus.instr_ready_out !== 1'b0) begin
         errors++; $display("FAIL b2b_ready_low: got %b expected 0", bus.instr_ready_out);
      end
      step();
      checks++;
      if (bus.dec_pc_out !== 64'h2000 || bus.dec_imm_out !== 64'd1 || bus.instr_ready_out !== 1'b0) begin
         errors++; $display("FAIL b2b_stall: got pc %h imm %h ready %b expected 2000 1 0",
                            bus.dec_pc_out, bus.dec_imm_out, bus.instr_ready_out);
      end
      bus.dec_ready_in = 1'b1;
      step();
      checks++;
      if (bus.dec_valid_out !== 1'b1 || bus.dec_pc_out !== 64'h2004 || bus.dec_imm_out !== 64'd2 ||
          bus.instr_ready_out !== 1'b1) begin
         errors++; $display("FAIL b2b_second: got valid %b pc %h imm %h ready %b expected 1 2004 2 1",
                            bus.dec_valid_out, bus.dec_pc_out, bus.dec_imm_out, bus.instr_ready_out);
      end
      step();
      checks++;
      if (bus.dec_valid_out !== 1'b0) begin
         errors++; $display("FAIL b2b_empty: got valid %b expected 0", bus.dec_valid_out);
      end
   endtask

   task automatic test_flush();
      bus.dec_ready_in = 1'b0;
      bus.instr_valid_in = 1'b1;
      bus.instr_in = 32'h00100093;
      bus.pc_in = 64'h3000;
      step();
      bus.instr_in = 32'h00200113;
      bus.pc_in = 64'h3004;
      step();
      bus.instr_in = 32'h00300193;
      bus.pc_in = 64'h3008;
      flush = 1'b1;
      step();
      flush = 1'b0;
      checks++;
      if (bus.dec_valid_out !== 1'b0 || bus.instr_ready_out !== 1'b1) begin
         errors++; $display("FAIL flush_state: got valid %b ready %b expected 0 1",
                            bus.dec_valid_out, bus.instr_ready_out);
      end
      bus.instr_valid_in = 1'b0;
      bus.dec_ready_in = 1'b1;
      step();
      step();
      checks++;
      if (bus.dec_valid_out !== 1'b0) begin
         errors++; $display("FAIL flush_drop: got valid %b pc %h expected 0",
                            bus.dec_valid_out, bus.dec_pc_out);
      end
   endtask

   task automatic test_reset_mid();
      bus.dec_ready_in = 1'b0;
      bus.instr_valid_in = 1'b1;
      bus.instr_in = 32'h00500293;
      bus.pc_in = 64'h5000;
      step();
      bus.instr_valid_in = 1'b0;
      checks++;
      if (bus.dec_valid_out !== 1'b1) begin
         errors++; $display("FAIL rstmid_full: got valid %b expected 1", bus.dec_valid_out);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (bus.dec_valid_out !== 1'b0 || bus.dec_fmt_out !== 3'd7 || bus.instr_ready_out !== 1'b1 ||
          bus.dec_instr_out !== 32'h0) begin
         errors++; $display("FAIL rstmid_state: got valid %b fmt %0d ready %b instr %h expected 0 7 1 0",
                            bus.dec_valid_out, bus.dec_fmt_out, bus.instr_ready_out, bus.dec_instr_out);
      end
   endtask

   task automatic test_illegal();
      bus.dec_ready_in = 1'b1;
      bus.instr_valid_in = 1'b1;
      bus.instr_in = 32'h0000007F;
      bus.pc_in = 64'h6000;
      step();
      bus.instr_valid_in = 1'b0;
`ifdef IMM_ILLEGAL_TRAP_EN
      checks++;
      if (bus.dec_fmt_out !== 3'd7 || bus.dec_imm_out !== 64'd0 || bus.illegal_out !== 1'b1) begin
         errors++; $display("FAIL illegal_trap: got fmt %0d imm %h ill %b expected 7 0 1",
                            bus.dec_fmt_out, bus.dec_imm_out, bus.illegal_out);
      end
`else
      checks++;
      if (bus.dec_fmt_out !== 3'd0 || bus.dec_imm_out !== 64'd0 || bus.illegal_out !== 1'b0) begin
         errors++; $display("FAIL illegal_default: got fmt %0d imm %h ill %b expected 0 0 0",
                            bus.dec_fmt_out, bus.dec_imm_out, bus.illegal_out);
      end
`endif
      checks++;
      if (bus.dec_valid_out !== 1'b1) begin
         errors++; $display("FAIL illegal_valid: got %b expected 1", bus.dec_valid_out);
      end
      step();
      checks++;
      if (bus.dec_valid_out !== 1'b0 || bus.illegal_out !== 1'b0) begin
         errors++; $display("FAIL illegal_drain: got valid %b ill %b expected 0 0",
                            bus.dec_valid_out, bus.illegal_out);
      end
   endtask

   initial begin
      bus.instr_valid_in = 1'b0;
      bus.instr_in = 32'h0;
      bus.pc_in = 64'h0;
      bus.dec_ready_in = 1'b0;
      test_reset();
      test_addi();
      test_formats();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_illegal();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imm_decode_stage.md
Name: imm_decode_stage

Overview:
- Decode-stage controller for the 64-bit core's immediate datapath, between fetch and execute.
- Classifies each 32-bit instruction into an immediate format and drives the format select of the combinational immediate mux.
- Captures the mux result together with the instruction and PC into a 2-entry skid-buffered pipeline register with valid/ready handshakes on both sides.
- Supports flush.

Parameters:
- XLEN, 64, datapath and immediate width.
- PC_W, 64, program counter width.

Ports:
- clk_in  input  1  core clock.
- reset_in  input  1  synchronous active-high reset.
- flush_in  input  1  discard all held and incoming entries.
- instr_valid_in  input  1  fetch offers instruction.
- instr_ready_out  output  1  stage can accept.
- instr_in  input  32  instruction word.
- pc_in  input  PC_W  instruction PC.
- imm_sel_out  output  3  format code to immediate mux.
- imm_value_in  input  XLEN  immediate returned by mux, same cycle.
- dec_valid_out  output  1  decoded entry valid.
- dec_ready_in  input  1  execute accepts.
- dec_instr_out  output  32  held instruction.
- dec_pc_out  output  PC_W  held PC.
- dec_imm_out  output  XLEN  held immediate.
- dec_fmt_out  output  3  held format code.
- illegal_out  output  1  held entry has an unknown opcode.

Behaviour:
- One clock domain. Reset is synchronous and active-high, on clk_in / reset_in.
- Format codes: I=0, S=1, B=2, U=3, J=4, SHAMT=5, ZIMM=6, NONE=7.
- Decode is combinational from instr_in[6:0]:
  - LOAD 0000011, JALR 1100111, FENCE 0001111 -> I.
  - OP-IMM 0010011 and OP-IMM-32 0011011 -> SHAMT if funct3 is 001 or 101, else I.
  - STORE 0100011 -> S. BRANCH 1100011 -> B.
  - LUI 0110111, AUIPC 0010111 -> U. JAL 1101111 -> J.
  - SYSTEM 1110011 -> ZIMM if funct3[2]=1, else I.
  - OP 0110011, OP-32 0111011 -> NONE.
  - Any other opcode -> see Optional Feature.
- imm_sel_out always reflects decode of the current instr_in, whether or not the instruction is accepted.
- On accept of a NONE-format instruction, the stored immediate is 0; imm_value_in is ignored.
- Accept: instr_valid_in & instr_ready_out. Issue: dec_valid_out & dec_ready_in.
- States:
  - EMPTY: dec_valid_out=0, instr_ready_out=1.
  - FULL: output register valid, skid empty, instr_ready_out=1.
  - SKID: output and skid both valid, instr_ready_out=0.
- instr_ready_out is a registered function of state: low only in SKID. It never depends combinationally on dec_ready_in.
- Transitions:
  - EMPTY + accept -> FULL. Entry loads the output register. Latency 1 cycle.
  - FULL + accept + issue -> FULL. Output register reloads with the new entry.
  - FULL + accept + no issue -> SKID. New entry goes to the skid register.
  - FULL + issue only -> EMPTY.
  - SKID + issue -> FULL. Skid entry moves to the output register.
  - SKID + no issue -> SKID.
- Program order is always preserved.
- Output register contents are stable while dec_valid_out=1 and dec_ready_in=0.
- flush_in has highest priority:
  - Next state is EMPTY and both registers are invalidated.
  - An instruction offered in the flush cycle is dropped.
  - instr_ready_out=1 in the cycle after the flush.
- Reset (including mid-operation): state EMPTY, dec_valid_out=0, instr_ready_out=1, illegal_out=0.
- Reset values of data outputs: dec_instr_out=0, dec_pc_out=0, dec_imm_out=0, dec_fmt_out=7.
- Reset overrides flush.
- Data registers load only on accept. The enable is gated by valid, so there is no X propagation from an idle input.

Optional Feature:
- Macro IMM_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcodes decode as NONE with immediate 0.
  - The entry carries illegal=1 and is presented on illegal_out with its entry.
  - Handshake is unchanged; execute raises the trap.
- Undefined:
  - Unknown opcodes decode as I.
  - illegal_out is tied to 0.
  - No illegal bit is stored.

Test Plan:
- Bench models the mux. ADDI 0xFFF00093 at pc 0x1000 in EMPTY, dec_ready_in=1 -> imm_sel_out=0 same cycle. Next cycle dec_valid_out=1, fmt=0, imm=0xFFFFFFFFFFFFFFFF, pc=0x1000.
- Format decode of SLLI 0x00309093, SW 0x00112023, BEQ 0x00000463, LUI 0x123450B7, JAL 0x0080006F, CSRRWI 0x3405D073, ADD 0x002081B3 -> fmt 5, 1, 2, 3, 4, 6, 7. ADD stores imm=0.
- Back-to-back 0x00100093, 0x00200113 with dec_ready_in=0 for 3 cycles:
  - instr_ready_out=0 after the second accept.
  - On release, both issue in order on consecutive cycles, then EMPTY.
- flush_in asserted in SKID while offering a third instruction -> next cycle dec_valid_out=0, instr_ready_out=1. The third instruction never issues.
- reset_in asserted in FULL with dec_ready_in=0 -> next cycle dec_valid_out=0, dec_fmt_out=7, instr_ready_out=1.
- IMM_ILLEGAL_TRAP_EN defined, instr 0x0000007F -> fmt=7, imm=0, illegal_out=1. Undefined -> fmt=0, illegal_out=0.
